game_engine: RTL
================

GAME_ENGINE -- requirements
Module: game_engine

Interface
REQ-001 Parameter TICK_DIV, default 416667, dclk cycles per physics tick (60 Hz at 25 MHz).
REQ-002 Parameter PIPE_SPEED, default 2, pipe advance in pixels per tick.
REQ-003 Parameter FLAP_VEL, default 8, signed upward velocity loaded on flap.
REQ-004 Reset clr, asynchronous, active-high; clock dclk.
REQ-005 dclk  in  1  pixel clock, 25 MHz.
REQ-006 clr  in  1  asynchronous active-high reset.
REQ-007 flap_btn  in  1  raw asynchronous push-button, active-high.
REQ-008 bird_coord  out  10  bird centre height in pixels above the screen bottom.
REQ-009 pipe_pos  out  9  scroll offset of the pipe pair, 0..344.
REQ-010 pipe_array0  out  8  gap offset of the leading (left) pipe.
REQ-011 pipe_array1  out  8  gap offset of the trailing (right) pipe.
REQ-012 current_score  out  4  pipes passed.
REQ-013 game_over  out  1  high in DEAD state.

Function
REQ-014 Tick generator: counter 0..TICK_DIV-1; 1-cycle tick when it equals TICK_DIV-1, then wraps to 0; free-running in all states.
REQ-015 flap_btn: 2-FF synchronizer, then rising-edge detect; an edge sets flap_pend; flap_pend clears on the next tick; multiple edges between ticks count as one.
REQ-016 FSM states: IDLE, PLAY, DEAD; all state and position updates occur only on tick cycles.
REQ-017 IDLE: outputs hold their reset values; a tick with flap_pend moves to PLAY and applies the flap on the same tick.
REQ-018 PLAY velocity: vel is signed 6-bit; on a tick, vel <= FLAP_VEL if flap_pend, else max(vel-1, -16).
REQ-019 PLAY position: bird_coord <= clamp(bird_coord+vel, 0, 430); clamping at 430 also forces vel to 0.
REQ-020 PLAY pipes: if pipe_pos+PIPE_SPEED >= 345, pipe_pos <= pipe_pos+PIPE_SPEED-345, pipe_array0 <= pipe_array1, and pipe_array1 <= 40 + (lfsr[6:0]); otherwise pipe_pos <= pipe_pos+PIPE_SPEED.
REQ-021 LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5; advances every dclk cycle in all states.
REQ-022 Score: +1 on a PLAY tick where the old pipe_pos < 255 and the new (unwrapped) pipe_pos >= 255; saturates at 15.
REQ-023 Collision is evaluated on post-update values, in 11-bit unsigned arithmetic, with Y = 480 - bird_coord.
REQ-024 Collision exists when bird_coord <= 20 (ground), or when pipe_pos is in 156..254 and (Y-19 < pipe_array0+75 or Y+19 > pipe_array0+215).
REQ-025 Collision on a PLAY tick moves to DEAD on that tick; the score increment still applies if the same tick also crosses the score point.
REQ-026 DEAD: all outputs frozen; game_over = 1; a tick with flap_pend returns to IDLE and reloads the reset values of bird_coord, pipe_pos, pipe arrays, score and vel.
REQ-027 All outputs are registered; they change only in the cycle after a tick; latency from flap edge to motion is 3 dclk cycles plus up to one tick period.

Reset
REQ-028 clr asserted: state=IDLE, bird_coord=240, pipe_pos=0, pipe_array0=100, pipe_array1=60, current_score=0, game_over=0, vel=0, flap_pend=0, tick counter=0, lfsr=8'hA5, synchronizer=0.
REQ-029 clr asserted mid-game overrides any tick in the same cycle; the first tick after release occurs TICK_DIV cycles later.

Structure
REQ-030 Package game_pkg holds the state enum, the constants 345, 430, 240, 20, 40, 75, 215, 19, 156, 254, 255 and the LFSR seed/taps.
REQ-031 One sub-module, flap_sync (synchronizer plus edge detector), shall be used; all other logic shall be in game_engine.

Verification
REQ-032 TICK_DIV=4 for all benches; clr pulse -> every output equals its REQ-028 value and tick spacing is 4 cycles.
REQ-033 IDLE, flap, next tick -> state PLAY, vel=8, bird_coord=248; 9 further ticks with no flap -> bird_coord=284, vel=-1.
REQ-034 PLAY with pipe_pos=344 at a tick -> pipe_pos=1; pipe_array0 takes the old pipe_array1; new pipe_array1 is in 40..167.
REQ-035 pipe_pos=254 -> 256 with the bird in the gap -> current_score +1; forced score 15 -> remains 15.
REQ-036 No flap from bird_coord=240 -> DEAD once bird_coord <= 20, game_over=1, outputs frozen; flap -> IDLE with reset values.
REQ-037 pipe_array0=100, pipe_pos=200, bird_coord=430 -> DEAD on that tick (Y-19=31 < 175).

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird style game engine.
// Holds the FSM state type, the screen/pipe geometry constants and the
// LFSR seed, taps and step function used for the pipe gap offsets.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DEAD
    } state_t;

    // Pipe scroll range and scoring point
    localparam int unsigned PIPE_WRAP  = 345;
    localparam int unsigned SCORE_PT   = 255;
    localparam int unsigned ZONE_LO    = 156;
    localparam int unsigned ZONE_HI    = 254;

    // Bird geometry (heights above the screen bottom)
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned BIRD_MAX   = 430;
    localparam int unsigned BIRD_START = 240;
    localparam int unsigned GROUND     = 20;
    localparam int unsigned BIRD_HALF  = 19;

    // Gap geometry relative to a pipe's gap offset
    localparam int unsigned GAP_BASE   = 40;
    localparam int unsigned GAP_LO     = 75;
    localparam int unsigned GAP_HI     = 215;

    // Reset values of the pipe gap offsets
    localparam logic [7:0] PA0_RST     = 8'd100;
    localparam logic [7:0] PA1_RST     = 8'd60;

    localparam logic signed [5:0] VEL_MIN = -6'sd16;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/flap_sync.sv
// Push-button front end: two-flop synchronizer followed by a rising-edge
// detector.
// Ports:
//   dclk - pixel clock
//   clr  - asynchronous active-high reset
//   btn  - raw asynchronous button input
//   rise - one-cycle pulse on each synchronized rising edge
module flap_sync (
    input  logic dclk,
    input  logic clr,
    input  logic btn,
    output logic rise
);

    // sr[0], sr[1]: synchronizer stages; sr[2]: previous synchronized value
    logic [2:0] sr;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], btn};
        end
    end

    assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/game_engine.sv
// Game engine: physics tick generator, flap input handling, IDLE/PLAY/DEAD
// state machine, bird motion, pipe scrolling, scoring and collision.
// Ports:
//   dclk          - pixel clock
//   clr           - asynchronous active-high reset
//   flap_btn      - raw asynchronous flap button
//   bird_coord    - bird centre height above the screen bottom
//   pipe_pos      - scroll offset of the pipe pair (0..344)
//   pipe_array0   - gap offset of the leading pipe
//   pipe_array1   - gap offset of the trailing pipe
//   current_score - pipes passed (saturating at 15)
//   game_over     - high while in the DEAD state
module game_engine
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 416667,
    parameter int unsigned PIPE_SPEED = 2,
    parameter int          FLAP_VEL   = 8
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       flap_btn,
    output logic [9:0] bird_coord,
    output logic [8:0] pipe_pos,
    output logic [7:0] pipe_array0,
    output logic [7:0] pipe_array1,
    output logic [3:0] current_score,
    output logic       game_over
);

    localparam int unsigned       CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [5:0] VEL_FLAP = 6'(FLAP_VEL);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              flap_rise, flap_pend;
    logic              do_play, do_restart;
    logic [7:0]        lfsr;

    logic signed [5:0] vel_q, vel_step, vel_d;
    logic [11:0]       bird_sum;
    logic [9:0]        bird_d;
    logic [9:0]        pipe_adv;
    logic [8:0]        pipe_d;
    logic [7:0]        pa0_d, pa1_d;
    logic [3:0]        score_d;
    logic              wrap, score_cross, in_zone, collide;
    logic [10:0]       y, y_lo, y_hi, gap_lo, gap_hi;

    // ---------------------------------------------------------------
    // Tick generator, free-running in every state
    // ---------------------------------------------------------------
    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Flap input: a pending request survives until the next tick
    // ---------------------------------------------------------------
    flap_sync u_flap_sync (
        .dclk (dclk),
        .clr  (clr),
        .btn  (flap_btn),
        .rise (flap_rise)
    );

    // An edge arriving on a tick cycle wins, so it is kept for the next tick
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            flap_pend <= 1'b0;
        end else if (flap_rise) begin
            flap_pend <= 1'b1;
        end else if (tick) begin
            flap_pend <= 1'b0;
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // ---------------------------------------------------------------
    // Candidate next values for a playing tick
    // ---------------------------------------------------------------
    always_comb begin
        // A flap moves the bird by FLAP_VEL at once; otherwise the bird moves
        // by the velocity held before this tick's decrement.
        vel_step = flap_pend ? VEL_FLAP : vel_q;

        if (flap_pend) begin
            vel_d = VEL_FLAP;
        end else if (vel_q == VEL_MIN) begin
            vel_d = VEL_MIN;
        end else begin
            vel_d = vel_q - 6'sd1;
        end

        bird_sum = {2'b00, bird_coord} + {{6{vel_step[5]}}, vel_step};
        if (bird_sum[11]) begin
            bird_d = '0;
        end else if (bird_sum[10:0] > 11'(BIRD_MAX)) begin
            bird_d = 10'(BIRD_MAX);
            vel_d  = '0;
        end else begin
            bird_d = bird_sum[9:0];
        end

        pipe_adv = {1'b0, pipe_pos} + 10'(PIPE_SPEED);
        wrap     = (pipe_adv >= 10'(PIPE_WRAP));
        pipe_d   = wrap ? 9'(pipe_adv - 10'(PIPE_WRAP)) : pipe_adv[8:0];
        pa0_d    = wrap ? pipe_array1 : pipe_array0;
        pa1_d    = wrap ? (8'(GAP_BASE) + {1'b0, lfsr[6:0]}) : pipe_array1;

        // Scoring uses the unwrapped advance
        score_cross = ({1'b0, pipe_pos} < 10'(SCORE_PT)) && (pipe_adv >= 10'(SCORE_PT));
        score_d     = (score_cross && (current_score != 4'hF)) ? current_score + 4'd1
                                                              : current_score;

        // Collision on post-update values; Y is measured down from the top
        y       = 11'(SCREEN_H) - {1'b0, bird_d};
        y_lo    = y - 11'(BIRD_HALF);
        y_hi    = y + 11'(BIRD_HALF);
        gap_lo  = {3'b000, pa0_d} + 11'(GAP_LO);
        gap_hi  = {3'b000, pa0_d} + 11'(GAP_HI);
        in_zone = (pipe_d >= 9'(ZONE_LO)) && (pipe_d <= 9'(ZONE_HI));
        collide = (bird_d <= 10'(GROUND)) ||
                  (in_zone && ((y_lo < gap_lo) || (y_hi > gap_hi)));
    end

    // ---------------------------------------------------------------
    // FSM: state register / next state / control outputs
    // ---------------------------------------------------------------
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: if (flap_pend) state_d = collide ? ST_DEAD : ST_PLAY;
                ST_PLAY: if (collide)   state_d = ST_DEAD;
                ST_DEAD: if (flap_pend) state_d = ST_IDLE;
                default:                state_d = ST_IDLE;
            endcase
        end
    end

    // The starting flap from IDLE is a full playing tick
    always_comb begin
        do_play    = 1'b0;
        do_restart = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: do_play    = flap_pend;
                ST_PLAY: do_play    = 1'b1;
                ST_DEAD: do_restart = flap_pend;
                default: do_restart = 1'b1;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Registered game state and outputs
    // ---------------------------------------------------------------
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            bird_coord    <= 10'(BIRD_START);
            vel_q         <= '0;
            pipe_pos      <= '0;
            pipe_array0   <= PA0_RST;
            pipe_array1   <= PA1_RST;
            current_score <= '0;
            game_over     <= 1'b0;
        end else begin
            game_over <= (state_d == ST_DEAD);
            if (do_restart) begin
                bird_coord    <= 10'(BIRD_START);
                vel_q         <= '0;
                pipe_pos      <= '0;
                pipe_array0   <= PA0_RST;
                pipe_array1   <= PA1_RST;
                current_score <= '0;
            end else if (do_play) begin
                bird_coord    <= bird_d;
                vel_q         <= vel_d;
                pipe_pos      <= pipe_d;
                pipe_array0   <= pa0_d;
                pipe_array1   <= pa1_d;
                current_score <= score_d;
            end
        end
    end

endmodule
